// File: rtl/result_quantizer.sv
// result_quantizer: requantizes systolic-array accumulators to int8 behind a credit-checked FIFO.
// Optional ReLU clamp at the zero point is enabled by defining QUANT_RELU_EN.
module result_quantizer #(
    parameter int LANES      = 4,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 8,
    parameter int SCALE_W    = 16,
    parameter int SHIFT_W    = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic [SCALE_W-1:0]       cfg_scale,
    input  logic [SHIFT_W-1:0]       cfg_shift,
    input  logic [OUT_W-1:0]         cfg_zp,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*ACC_W-1:0]   in_acc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   out_q,
    output logic [15:0]              sat_count,
    output logic                     busy
);

    localparam int PROD_W = ACC_W + SCALE_W;
    localparam int SUM_W  = PROD_W + 2;
    localparam int NSAT_W = $clog2(LANES + 1);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 2;

    localparam logic signed [SUM_W-1:0] QMAX = SUM_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] QMIN = ~QMAX;

    logic [SCALE_W-1:0]           scale_r;
    logic [SHIFT_W-1:0]           shift_r;
    logic [OUT_W-1:0]             zp_r;

    logic                         p1_valid;
    logic [LANES*PROD_W-1:0]      p1_prod;
    logic [SHIFT_W-1:0]           p1_shift;
    logic signed [OUT_W-1:0]      p1_zp;

    logic                         p2_valid;
    logic [LANES*OUT_W-1:0]       p2_q;

    logic [LANES*OUT_W-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic [AW:0]                  fifo_count;

    logic                         accept;
    logic                         fifo_push;
    logic                         fifo_pop;
    logic [LANES*PROD_W-1:0]      prod_c;
    logic signed [PROD_W-1:0]     acc_ext;
    logic signed [PROD_W-1:0]     scl_ext;
    logic [LANES*OUT_W-1:0]       q_c;
    logic [NSAT_W-1:0]            nsat_c;
    logic signed [SUM_W-1:0]      rnd;
    logic signed [SUM_W-1:0]      sum;
    logic signed [SUM_W-1:0]      r;
    logic signed [SUM_W-1:0]      v;
    logic [16:0]                  sat_sum;
    logic [CW-1:0]                credits;

    // Credits cover every beat already committed to land in the FIFO.
    always_comb begin
        credits = CW'(fifo_count) + CW'(p1_valid) + CW'(p2_valid);
        in_ready = credits < CW'(FIFO_DEPTH);
        accept = in_valid && in_ready;
        out_valid = fifo_count != '0;
        fifo_push = p2_valid;
        fifo_pop = out_valid && out_ready;
        busy = p1_valid | p2_valid | out_valid;
        out_q = out_valid ? mem[rd_ptr] : '0;
    end

    // Per-lane product with the scale treated as unsigned.
    always_comb begin
        prod_c = '0;
        acc_ext = '0;
        scl_ext = '0;
        for (int l = 0; l < LANES; l++) begin
            acc_ext = PROD_W'($signed(in_acc[l*ACC_W +: ACC_W]));
            scl_ext = PROD_W'(scale_r);
            prod_c[l*PROD_W +: PROD_W] = acc_ext * scl_ext;
        end
    end

    // Rounding shift, zero-point add, optional ReLU, saturation.
    always_comb begin
        q_c = '0;
        nsat_c = '0;
        sum = '0;
        r = '0;
        v = '0;
        rnd = '0;
        if (p1_shift != '0)
            rnd = SUM_W'(1) <<< (p1_shift - SHIFT_W'(1));
        for (int l = 0; l < LANES; l++) begin
            sum = SUM_W'($signed(p1_prod[l*PROD_W +: PROD_W])) + rnd;
            r = sum >>> p1_shift;
            v = r + SUM_W'(p1_zp);
`ifdef QUANT_RELU_EN
            if (v < SUM_W'(p1_zp))
                v = SUM_W'(p1_zp);
`endif
            if (v > QMAX) begin
                v = QMAX;
                nsat_c = nsat_c + NSAT_W'(1);
            end else if (v < QMIN) begin
                v = QMIN;
                nsat_c = nsat_c + NSAT_W'(1);
            end
            q_c[l*OUT_W +: OUT_W] = v[OUT_W-1:0];
        end
        sat_sum = 17'(sat_count) + 17'(nsat_c);
    end

    // Config registers; a beat accepted on the write edge sees the old values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scale_r <= SCALE_W'(1);
            shift_r <= '0;
            zp_r <= '0;
        end else if (cfg_we) begin
            scale_r <= cfg_scale;
            shift_r <= cfg_shift;
            zp_r <= cfg_zp;
        end
    end

    // Two pipeline stages; config travels with the beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1_valid <= 1'b0;
            p1_prod <= '0;
            p1_shift <= '0;
            p1_zp <= '0;
            p2_valid <= 1'b0;
            p2_q <= '0;
        end else begin
            p1_valid <= accept;
            if (accept) begin
                p1_prod <= prod_c;
                p1_shift <= shift_r;
                p1_zp <= zp_r;
            end
            p2_valid <= p1_valid;
            if (p1_valid)
                p2_q <= q_c;
        end
    end

    // Saturation counter sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sat_count <= '0;
        else if (p1_valid)
            sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end

    // FIFO storage needs no reset; the count gates visibility.
    always_ff @(posedge clk) begin
        if (fifo_push)
            mem[wr_ptr] <= p2_q;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (fifo_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (fifo_push && !fifo_pop)
                fifo_count <= fifo_count + (AW+1)'(1);
            else if (fifo_pop && !fifo_push)
                fifo_count <= fifo_count - (AW+1)'(1);
        end
    end

endmodule

// File: tb/tb_result_quantizer.sv
// tb_result_quantizer: scoreboard bench for result_quantizer.
// Expected beats come from a wide-integer reference model at accept time.
module tb_result_quantizer;

    logic         clk;
    logic         reset;
    logic         cfg_we;
    logic [15:0]  cfg_scale;
    logic [5:0]   cfg_shift;
    logic [7:0]   cfg_zp;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_acc;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_q;
    logic [15:0]  sat_count;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;
    int n_pop = 0;
    int m_scale = 1;
    int m_shift = 0;
    int m_zp = 0;
    int exp_sat = 0;
    logic [31:0] sb [$];

    result_quantizer dut (
        .clk(clk),
        .reset(reset),
        .cfg_we(cfg_we),
        .cfg_scale(cfg_scale),
        .cfg_shift(cfg_shift),
        .cfg_zp(cfg_zp),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_acc(in_acc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_q(out_q),
        .sat_count(sat_count),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack4(input int a, input int b,
                                           input int c, input int d);
        return {d, c, b, a};
    endfunction

    function automatic logic [31:0] model(input logic [127:0] acc,
                                          output int nsat);
        logic [31:0] e;
        longint a, p, r, v;
        e = '0;
        nsat = 0;
        for (int l = 0; l < 4; l++) begin
            a = longint'($signed(acc[l*32 +: 32]));
            p = a * longint'(m_scale);
            if (m_shift > 0)
                r = (p + (longint'(1) << (m_shift - 1))) >>> m_shift;
            else
                r = p;
            v = r + longint'(m_zp);
`ifdef QUANT_RELU_EN
            if (v < longint'(m_zp))
                v = longint'(m_zp);
`endif
            if (v > 127) begin
                v = 127;
                nsat++;
            end else if (v < -128) begin
                v = -128;
                nsat++;
            end
            e[l*8 +: 8] = v[7:0];
        end
        return e;
    endfunction

    // Scoreboard: sample just before each rising edge.
    always begin
        int ns;
        logic [31:0] e;
        @(negedge clk);
        #3;
        if (reset) begin
            if (out_valid && out_ready) begin
                n_pop++;
                if (sb.size() == 0)
                    check("unexpected_beat", out_q, 32'hx);
                else begin
                    e = sb.pop_front();
                    check("out_q", out_q, e);
                end
            end
            if (in_valid && in_ready) begin
                n_acc++;
                e = model(in_acc, ns);
                sb.push_back(e);
                exp_sat = exp_sat + ns;
                if (exp_sat > 65535)
                    exp_sat = 65535;
            end
            if (cfg_we) begin
                m_scale = int'(cfg_scale);
                m_shift = int'(cfg_shift);
                m_zp = int'($signed(cfg_zp));
            end
        end
    end

    task automatic send(input logic [127:0] a);
        int n0;
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_acc = a;
        n0 = n_acc;
        t = 0;
        while (n_acc == n0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("accept", 64'(n_acc != n0), 64'(1));
    endtask

    task automatic set_cfg(input int s, input int sh, input int z);
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we = 1'b1;
        cfg_scale = 16'(s);
        cfg_shift = 6'(sh);
        cfg_zp = 8'(z);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain", 64'(t < 200), 64'(1));
    endtask

    initial begin
        int base;
        reset = 1'b0;
        cfg_we = 1'b0;
        cfg_scale = 16'd1;
        cfg_shift = '0;
        cfg_zp = '0;
        in_valid = 1'b0;
        in_acc = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_q", 64'(out_q), 64'(0));
        check("rst_sat", 64'(sat_count), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Pass-through and two-cycle latency
        send(pack4(5, -3, 127, -128));
        in_valid = 1'b0;
        check("lat_n0", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        check("lat_n1", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        check("lat_n2", 64'(out_valid), 64'(1));
        check("lat_q", 64'(out_q), 64'(32'h80_7F_FD_05));
        drain();
        check("sat_t1", 64'(sat_count), 64'(0));

        // Saturation both directions
        send(pack4(300, -300, 1000000, -1));
        in_valid = 1'b0;
        drain();
        check("sat_t2", 64'(sat_count), 64'(3));

        // Scale, rounding shift, zero point
        set_cfg(3, 2, 0);
        send(pack4(5, 6, -5, -6));
        in_valid = 1'b0;
        drain();
        set_cfg(3, 2, -2);
        send(pack4(5, 6, -5, -6));
        in_valid = 1'b0;
        drain();

        // Back-pressure and credit limit
        set_cfg(1, 0, 0);
        out_ready = 1'b0;
        base = n_acc;
        for (int k = 1; k <= 4; k++)
            send(pack4(k, -k, 10 * k, k + 100));
        @(negedge clk);
        in_acc = pack4(5, -5, 50, 105);
        repeat (6) @(negedge clk);
        check("credit_accepts", 64'(n_acc - base), 64'(4));
        check("credit_ready", 64'(in_ready), 64'(0));
        base = n_pop;
        out_ready = 1'b1;
        send(pack4(5, -5, 50, 105));
        send(pack4(6, -6, 60, 106));
        in_valid = 1'b0;
        drain();
        check("credit_pops", 64'(n_pop - base), 64'(6));

        // Config write on the accept edge
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_scale = 16'd2;
        in_valid = 1'b1;
        in_acc = pack4(10, 20, 30, 40);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        send(pack4(10, 20, 30, 40));
        in_valid = 1'b0;
        drain();

        // Reset with beats in flight
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            send(pack4(100, -100, 1, 1));
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_sat", 64'(sat_count), 64'(0));
        sb.delete();
        exp_sat = 0;
        m_scale = 1;
        m_shift = 0;
        m_zp = 0;
        cfg_scale = 16'd1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        base = n_pop;
        repeat (8) @(negedge clk);
        check("no_stale", 64'(n_pop - base), 64'(0));
        send(pack4(7, 8, 9, 10));
        in_valid = 1'b0;
        drain();
        check("post_rst_sat", 64'(sat_count), 64'(exp_sat));

`ifdef QUANT_RELU_EN
        set_cfg(1, 0, 10);
        send(pack4(-50, 0, 20, -200));
        in_valid = 1'b0;
        drain();
        check("relu_sat", 64'(sat_count), 64'(exp_sat));
`endif

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
